// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between the instruction-fetch
// port and the data port. Grants are decided combinationally each cycle, the
// SRAM is driven from the winning port, and read data is steered back one
// cycle later to whichever port issued the read.
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration with a
// symmetric starvation override; without it, D has fixed priority and only
// the fetch port has a starvation override.
module mem_port_arbiter #(
   parameter int AWIDTH   = 12,
   parameter int DWIDTH   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              I_REQ,
   input  logic [AWIDTH-1:0] I_ADDR,
   output logic              I_GNT,
   output logic              I_RVALID,
   output logic [DWIDTH-1:0] I_RDATA,
   input  logic              D_REQ,
   input  logic              D_WEN,
   input  logic [3:0]        D_BE,
   input  logic [AWIDTH-1:0] D_ADDR,
   input  logic [DWIDTH-1:0] D_WDATA,
   output logic              D_GNT,
   output logic              D_RVALID,
   output logic [DWIDTH-1:0] D_RDATA,
   output logic              M_CSN,
   output logic              M_WEN,
   output logic [3:0]        M_BE,
   output logic [AWIDTH-1:0] M_ADDR,
   output logic [DWIDTH-1:0] M_DI,
   input  logic [DWIDTH-1:0] M_DOUT,
   output logic [31:0]       STALL_CNT
);

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   logic [3:0] i_wait;
   logic       i_force;
   logic       pend;
   logic       owner_i;

`ifdef MEM_ARB_RR_EN
   typedef enum logic {PORT_D = 1'b0, PORT_I = 1'b1} port_t;

   logic [3:0] d_wait;
   logic       d_force;
   port_t      rr_ptr;
`endif

   // Grant decision: starvation override first, then the normal policy; reset blocks all grants
   always_comb begin
      I_GNT   = 1'b0;
      D_GNT   = 1'b0;
      i_force = I_REQ && (i_wait >= WAIT_LIMIT);
`ifdef MEM_ARB_RR_EN
      d_force = D_REQ && (d_wait >= WAIT_LIMIT);
      if (!RST) begin
         if (i_force)
            I_GNT = 1'b1;
         else if (d_force)
            D_GNT = 1'b1;
         else if (I_REQ && D_REQ) begin
            if (rr_ptr == PORT_I)
               I_GNT = 1'b1;
            else
               D_GNT = 1'b1;
         end
         else if (I_REQ)
            I_GNT = 1'b1;
         else if (D_REQ)
            D_GNT = 1'b1;
      end
`else
      if (!RST) begin
         if (i_force)
            I_GNT = 1'b1;
         else if (D_REQ)
            D_GNT = 1'b1;
         else if (I_REQ)
            I_GNT = 1'b1;
      end
`endif
   end

   // SRAM drive follows the winner; idle cycles park every field at a known value
   always_comb begin
      M_CSN  = 1'b1;
      M_WEN  = 1'b1;
      M_BE   = 4'b0000;
      M_ADDR = '0;
      M_DI   = '0;
      if (I_GNT) begin
         M_CSN  = 1'b0;
         M_ADDR = I_ADDR;
      end
      else if (D_GNT) begin
         M_CSN  = 1'b0;
         M_WEN  = D_WEN;
         M_BE   = D_BE;
         M_ADDR = D_ADDR;
         M_DI   = D_WDATA;
      end
   end

   // Read return: the SRAM output belongs to the port that issued last cycle's read
   always_comb begin
      I_RVALID = pend && owner_i && !RST;
      D_RVALID = pend && !owner_i && !RST;
      I_RDATA  = I_RVALID ? M_DOUT : '0;
      D_RDATA  = D_RVALID ? M_DOUT : '0;
   end

   // Pending-read tracking, wait counters, stall counter and round-robin pointer
   always_ff @(posedge CLK) begin
      if (RST) begin
         pend      <= 1'b0;
         owner_i   <= 1'b0;
         i_wait    <= 4'd0;
         STALL_CNT <= 32'd0;
`ifdef MEM_ARB_RR_EN
         d_wait    <= 4'd0;
         rr_ptr    <= PORT_D;
`endif
      end
      else begin
         pend    <= I_GNT || (D_GNT && D_WEN);
         owner_i <= I_GNT;

         if (I_REQ && !I_GNT)
            i_wait <= (i_wait == 4'hF) ? i_wait : i_wait + 4'd1;
         else
            i_wait <= 4'd0;

         if (((I_REQ && !I_GNT) || (D_REQ && !D_GNT)) && (STALL_CNT != 32'hFFFF_FFFF))
            STALL_CNT <= STALL_CNT + 32'd1;

`ifdef MEM_ARB_RR_EN
         if (D_REQ && !D_GNT)
            d_wait <= (d_wait == 4'hF) ? d_wait : d_wait + 4'd1;
         else
            d_wait <= 4'd0;

         if (I_GNT)
            rr_ptr <= PORT_D;
         else if (D_GNT)
            rr_ptr <= PORT_I;
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed test of mem_port_arbiter against a small
// byte-enabled single-port SRAM model with a one-cycle registered read.
// Expected grant patterns follow the MEM_ARB_RR_EN build selection.
module tb_mem_port_arbiter;

   logic        CLK;
   logic        RST;
   logic        I_REQ;
   logic [11:0] I_ADDR;
   logic        I_GNT;
   logic        I_RVALID;
   logic [31:0] I_RDATA;
   logic        D_REQ;
   logic        D_WEN;
   logic [3:0]  D_BE;
   logic [11:0] D_ADDR;
   logic [31:0] D_WDATA;
   logic        D_GNT;
   logic        D_RVALID;
   logic [31:0] D_RDATA;
   logic        M_CSN;
   logic        M_WEN;
   logic [3:0]  M_BE;
   logic [11:0] M_ADDR;
   logic [31:0] M_DI;
   logic [31:0] M_DOUT;
   logic [31:0] STALL_CNT;

   logic [31:0] mem [0:1023];

   int checkCount = 0;
   int passCount  = 0;

   mem_port_arbiter #(.AWIDTH(12), .DWIDTH(32), .MAX_WAIT(4)) dut (
      .CLK(CLK), .RST(RST),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
      .D_REQ(D_REQ), .D_WEN(D_WEN), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
      .M_CSN(M_CSN), .M_WEN(M_WEN), .M_BE(M_BE), .M_ADDR(M_ADDR), .M_DI(M_DI),
      .M_DOUT(M_DOUT), .STALL_CNT(STALL_CNT)
   );

   // Free-running clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // SRAM model: byte-enabled write, registered read on an enabled non-write access
   always @(posedge CLK) begin
      if (!M_CSN) begin
         if (!M_WEN) begin
            for (int b = 0; b < 4; b++)
               if (M_BE[b])
                  mem[M_ADDR[11:2]][8*b +: 8] <= M_DI[8*b +: 8];
         end
         else
            M_DOUT <= mem[M_ADDR[11:2]];
      end
   end

   task automatic applyStimulus(input logic ireq, input logic [11:0] iaddr,
                                input logic dreq, input logic dwen, input logic [3:0] dbe,
                                input logic [11:0] daddr, input logic [31:0] dwdata);
      I_REQ   = ireq;
      I_ADDR  = iaddr;
      D_REQ   = dreq;
      D_WEN   = dwen;
      D_BE    = dbe;
      D_ADDR  = daddr;
      D_WDATA = dwdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
   endtask

   task automatic nextCycle();
      @(posedge CLK);
      #1;
   endtask

   logic [5:0] expI;
   logic [5:0] expD;
   logic       prevI;
   logic       prevD;

   initial begin
      for (int w = 0; w < 1024; w++)
         mem[w] = 32'd0;
      mem[12'h010 >> 2] = 32'h0050_0093;
      mem[12'h200 >> 2] = 32'h1122_3344;
      M_DOUT = 32'd0;

`ifdef MEM_ARB_RR_EN
      expD = 6'b010101;
      expI = 6'b101010;
`else
      expD = 6'b101111;
      expI = 6'b010000;
`endif

      // Reset held three cycles with both ports requesting
      RST = 1'b1;
      applyStimulus(1'b1, 12'h010, 1'b1, 1'b1, 4'hF, 12'h020, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         checkOutput("rst_i_gnt", {31'd0, I_GNT}, 32'd0);
         checkOutput("rst_d_gnt", {31'd0, D_GNT}, 32'd0);
         checkOutput("rst_csn", {31'd0, M_CSN}, 32'd1);
         checkOutput("rst_rvalid", {30'd0, I_RVALID, D_RVALID}, 32'd0);
         if (c > 0)
            checkOutput("rst_stall", STALL_CNT, 32'd0);
         nextCycle();
      end
      RST = 1'b0;

      // Contention: both held high for six cycles
      prevI = 1'b0;
      prevD = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         checkOutput($sformatf("cont_i_gnt_%0d", k), {31'd0, I_GNT}, {31'd0, expI[k]});
         checkOutput($sformatf("cont_d_gnt_%0d", k), {31'd0, D_GNT}, {31'd0, expD[k]});
         checkOutput($sformatf("cont_i_rvalid_%0d", k), {31'd0, I_RVALID}, {31'd0, prevI});
         checkOutput($sformatf("cont_d_rvalid_%0d", k), {31'd0, D_RVALID}, {31'd0, prevD});
         checkOutput($sformatf("cont_addr_%0d", k), {20'd0, M_ADDR}, expI[k] ? 32'h010 : 32'h020);
         if (k == 5)
            checkOutput("cont_stall", STALL_CNT, 32'd5);
         prevI = expI[k];
         prevD = expD[k];
         nextCycle();
      end

      // Idle: last contention read returns, SRAM parked
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1, 4'h0, 12'h000, 32'd0);
      @(negedge CLK);
      checkOutput("idle_i_rvalid", {31'd0, I_RVALID}, {31'd0, prevI});
      checkOutput("idle_d_rvalid", {31'd0, D_RVALID}, {31'd0, prevD});
      checkOutput("idle_csn", {31'd0, M_CSN}, 32'd1);
      checkOutput("idle_addr", {20'd0, M_ADDR}, 32'd0);
      nextCycle();

      // Fetch only
      applyStimulus(1'b1, 12'h010, 1'b0, 1'b1, 4'h0, 12'h000, 32'd0);
      @(negedge CLK);
      checkOutput("fetch_gnt", {30'd0, I_GNT, D_GNT}, 32'd2);
      checkOutput("fetch_mem", {M_CSN, M_WEN, M_BE, 14'd0, M_ADDR}, {1'b0, 1'b1, 4'h0, 14'd0, 12'h010});
      nextCycle();
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1, 4'h0, 12'h000, 32'd0);
      @(negedge CLK);
      checkOutput("fetch_rvalid", {30'd0, I_RVALID, D_RVALID}, 32'd2);
      checkOutput("fetch_rdata", I_RDATA, 32'h0050_0093);
      checkOutput("fetch_d_rdata", D_RDATA, 32'd0);
      nextCycle();

      // D write then read
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0, 4'hF, 12'h100, 32'hDEAD_BEEF);
      @(negedge CLK);
      checkOutput("wr_gnt", {30'd0, I_GNT, D_GNT}, 32'd1);
      checkOutput("wr_mem", {M_CSN, M_WEN, M_BE, 14'd0, M_ADDR}, {1'b0, 1'b0, 4'hF, 14'd0, 12'h100});
      checkOutput("wr_di", M_DI, 32'hDEAD_BEEF);
      nextCycle();
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b1, 4'h0, 12'h100, 32'd0);
      @(negedge CLK);
      checkOutput("rd_gnt", {30'd0, I_GNT, D_GNT}, 32'd1);
      checkOutput("rd_no_rvalid", {30'd0, I_RVALID, D_RVALID}, 32'd0);
      checkOutput("rd_di", M_DI, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1, 4'h0, 12'h000, 32'd0);
      @(negedge CLK);
      checkOutput("rd_rvalid", {30'd0, I_RVALID, D_RVALID}, 32'd1);
      checkOutput("rd_rdata", D_RDATA, 32'hDEAD_BEEF);
      checkOutput("rd_i_rdata", I_RDATA, 32'd0);
      nextCycle();

      // Byte write into a preloaded word, then read back
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0, 4'b0010, 12'h200, 32'h0000_AB00);
      nextCycle();
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b1, 4'h0, 12'h200, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1, 4'h0, 12'h000, 32'd0);
      @(negedge CLK);
      checkOutput("be_rdata", D_RDATA, 32'h1122_AB44);
      checkOutput("stall_hold", STALL_CNT, 32'd6);
      nextCycle();

      // Read granted just before reset must not return after reset
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b1, 4'h0, 12'h100, 32'd0);
      @(negedge CLK);
      checkOutput("kill_gnt", {31'd0, D_GNT}, 32'd1);
      nextCycle();
      RST = 1'b1;
      @(negedge CLK);
      checkOutput("kill_rst_rvalid", {30'd0, I_RVALID, D_RVALID}, 32'd0);
      checkOutput("kill_rst_gnt", {30'd0, I_GNT, D_GNT}, 32'd0);
      checkOutput("kill_rst_csn", {31'd0, M_CSN}, 32'd1);
      nextCycle();
      RST = 1'b0;
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1, 4'h0, 12'h000, 32'd0);
      @(negedge CLK);
      checkOutput("kill_post_rvalid", {30'd0, I_RVALID, D_RVALID}, 32'd0);
      checkOutput("kill_post_stall", STALL_CNT, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
